mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and output stage for the W-bit N-input select mux.
- Shares one W-bit output channel among N requesters. Each requester has a req/ack handshake.
- Drives the mux select from the current grant and registers the selected word into a valid/ready output register.
- Sits between N producer blocks and a single downstream consumer.

---
 rtl/mux_rr_arbiter_if.sv | 26 ++
 rtl/mux_rr_arbiter.sv | 100 ++++++++++
 tb/tb_mux_rr_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between N producers, the arbiter, and the downstream consumer.
// slave = arbiter side, master = producer/consumer side.
interface mux_rr_arbiter_if #(
  parameter int N = 4,
  parameter int m = 2,
  parameter int W = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   ack;
  logic [m-1:0]   sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           busy;

  modport slave (
    input  req, data_in, out_ready,
    output ack, sel, out_data, out_valid, busy
  );

  modport master (
    output req, data_in, out_ready,
    input  ack, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter + registered W-bit output mux; ARB_FIXED_PRIO_EN selects highest-index priority.
// Latency: req to out_valid one cycle; one word per cycle with out_ready held high.
// Backpressure: FULL without out_ready holds all outputs and stops sampling requests.
module mux_rr_arbiter #(
  parameter int N = 4,
  parameter int m = 2,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t         r_state;
  logic           r_valid;
  logic [W-1:0]   r_data;
  logic [m-1:0]   r_sel;
  logic [m-1:0]   r_last;
  logic [N-1:0]   r_ack;

  logic           w_slot_free;
  logic [N-1:0]   w_elig;
  logic           w_found;
  logic [m-1:0]   w_win;
  logic [W-1:0]   w_word;

  assign w_slot_free = (r_state == IDLE) || (r_valid && bus.out_ready);
  // A requester being acked this cycle still shows its old req; never regrant it here.
  assign w_elig      = bus.req & ~r_ack;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    w_win = r_last;
    for (int i = 0; i < N; i++) begin
      if (w_elig[i]) w_win = m'(i);
    end
    w_found = |w_elig;
  end
`else
  // Two passes: indices above last_grant first, then wrap to the low end.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_elig[i] && (i > int'(r_last))) begin
        w_found = 1'b1;
        w_win   = m'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_elig[i] && (i <= int'(r_last))) begin
        w_found = 1'b1;
        w_win   = m'(i);
      end
    end
  end
`endif

  always_comb begin
    w_word = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == m'(i)) w_word = bus.data_in[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_last  <= m'(N-1);
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      if (w_slot_free) begin
        if (w_found) begin
          r_state <= FULL;
          r_valid <= 1'b1;
          r_data  <= w_word;
          r_sel   <= w_win;
          r_last  <= w_win;
          r_ack   <= {{(N-1){1'b0}}, 1'b1} << w_win;
        end else begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.ack       = r_ack;
  assign bus.sel       = r_sel;
  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.busy      = r_valid | (|bus.req);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter (N=4, m=2, W=4).
// Table rows are applied one clock each; reset cases are written out by hand.
module tb_mux_rr_arbiter;

  localparam int N = 4;
  localparam int M = 2;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_rr_arbiter_if #(.N(N), .m(M), .W(W)) bus ();

  mux_rr_arbiter #(.N(N), .m(M), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] din;
    logic        rdy;
    logic [1:0]  e_sel;
    logic [3:0]  e_dat;
    logic        e_vld;
    logic [3:0]  e_ack;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [15:0] D = 16'h1485;  // slices 3..0 = 0001,0100,1000,0101
  localparam logic [15:0] S = 16'h0100;  // slice 2 = 0001

  task automatic add(input logic [3:0] req, input logic [15:0] din, input logic rdy,
                     input logic [1:0] es, input logic [3:0] ed, input logic ev,
                     input logic [3:0] ea, input logic eb);
    vec_t v;
    v.req = req; v.din = din; v.rdy = rdy;
    v.e_sel = es; v.e_dat = ed; v.e_vld = ev; v.e_ack = ea; v.e_busy = eb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] es, input logic [3:0] ed,
                         input logic ev, input logic [3:0] ea, input logic eb);
    chk({tag, ".sel"},   int'(bus.sel),       int'(es));
    chk({tag, ".data"},  int'(bus.out_data),  int'(ed));
    chk({tag, ".valid"}, int'(bus.out_valid), int'(ev));
    chk({tag, ".ack"},   int'(bus.ack),       int'(ea));
    chk({tag, ".busy"},  int'(bus.busy),      int'(eb));
  endtask

  initial begin
    bus.req = '0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;

`ifdef ARB_FIXED_PRIO_EN
    add(4'b1111, D, 1, 2'd3, 4'b0001, 1, 4'b1000, 1);
    add(4'b1111, D, 1, 2'd2, 4'b0100, 1, 4'b0100, 1);
    add(4'b1111, D, 1, 2'd3, 4'b0001, 1, 4'b1000, 1);
    add(4'b1111, D, 1, 2'd2, 4'b0100, 1, 4'b0100, 1);
    add(4'b0000, D, 1, 2'd2, 4'b0100, 0, 4'b0000, 0);
`else
    // rotation from reset: 0,1,2,3,0
    add(4'b1111, D, 1, 2'd0, 4'b0101, 1, 4'b0001, 1);
    add(4'b1111, D, 1, 2'd1, 4'b1000, 1, 4'b0010, 1);
    add(4'b1111, D, 1, 2'd2, 4'b0100, 1, 4'b0100, 1);
    add(4'b1111, D, 1, 2'd3, 4'b0001, 1, 4'b1000, 1);
    add(4'b1111, D, 1, 2'd0, 4'b0101, 1, 4'b0001, 1);
    add(4'b0000, D, 1, 2'd0, 4'b0101, 0, 4'b0000, 0);
    // single requester 2
    add(4'b0100, S, 1, 2'd2, 4'b0001, 1, 4'b0100, 1);
    add(4'b0000, S, 1, 2'd2, 4'b0001, 0, 4'b0000, 0);
    // req held through its ack cycle: masked, then granted again
    add(4'b0100, S, 1, 2'd2, 4'b0001, 1, 4'b0100, 1);
    add(4'b0100, S, 1, 2'd2, 4'b0001, 0, 4'b0000, 1);
    add(4'b0100, S, 1, 2'd2, 4'b0001, 1, 4'b0100, 1);
    add(4'b0000, S, 1, 2'd2, 4'b0001, 0, 4'b0000, 0);
    // backpressure with req=1010, then successor of 3 is 1
    add(4'b1010, D, 0, 2'd3, 4'b0001, 1, 4'b1000, 1);
    add(4'b1010, D, 0, 2'd3, 4'b0001, 1, 4'b0000, 1);
    add(4'b1010, D, 0, 2'd3, 4'b0001, 1, 4'b0000, 1);
    add(4'b1010, D, 0, 2'd3, 4'b0001, 1, 4'b0000, 1);
    add(4'b1010, D, 1, 2'd1, 4'b1000, 1, 4'b0010, 1);
    add(4'b0000, D, 1, 2'd1, 4'b1000, 0, 4'b0000, 0);
    // wrap-around: grant 3, then req=1001 -> 0,3,0
    add(4'b1000, D, 1, 2'd3, 4'b0001, 1, 4'b1000, 1);
    add(4'b1001, D, 1, 2'd0, 4'b0101, 1, 4'b0001, 1);
    add(4'b1001, D, 1, 2'd3, 4'b0001, 1, 4'b1000, 1);
    add(4'b1001, D, 1, 2'd0, 4'b0101, 1, 4'b0001, 1);
    add(4'b0000, D, 1, 2'd0, 4'b0101, 0, 4'b0000, 0);
    // busy held by out_valid alone
    add(4'b0010, D, 0, 2'd1, 4'b1000, 1, 4'b0010, 1);
    add(4'b0000, D, 0, 2'd1, 4'b1000, 1, 4'b0000, 1);
    add(4'b0000, D, 1, 2'd1, 4'b1000, 0, 4'b0000, 0);
`endif

    #12;
    chk_all("reset", 2'd0, 4'h0, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      bus.req       = tbl[k].req;
      bus.data_in   = tbl[k].din;
      bus.out_ready = tbl[k].rdy;
      @(posedge clk);
      #1;
      chk_all($sformatf("row%0d", k), tbl[k].e_sel, tbl[k].e_dat,
              tbl[k].e_vld, tbl[k].e_ack, tbl[k].e_busy);
    end

    // reset while FULL drops everything without waiting for a clock
    bus.req = 4'b0010; bus.data_in = D; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_all("pre_rst", 2'd1, 4'b1000, 1'b1, 4'b0010, 1'b1);
    bus.req = 4'b0000;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 2'd0, 4'h0, 1'b0, 4'b0000, 1'b0);
    #3;
    rst = 1'b0;
    bus.req = 4'b0001; bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 2'd0, 4'b0101, 1'b1, 4'b0001, 1'b1);
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    chk_all("post_rst_drain", 2'd0, 4'b0101, 1'b0, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
